rtc_bus_cycle: RTL and testbench

Bus-cycle generator for the external RTC's multiplexed address/data bus. It sits directly downstream of the main RTC control FSM. It takes that FSM's write and read requests (`actesc`/`actlec`, `dirreg`, `datoreg`) and runs a complete two-phase chip access: an address phase followed by a data phase. It returns a level handshake (`esclisto`/`memorialisto`) and, for reads, the captured byte on `datomem`.

---
 rtl/rtc_bus_cycle_if.sv | 34 +++
 rtl/rtc_bus_cycle.sv | 203 ++++++++++++++++++++
 tb/tb_rtc_bus_cycle.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_cycle_if.sv
// Handshake and multiplexed AD-bus signals between the RTC control FSM,
// the pad ring and the rtc_bus_cycle generator.
interface rtc_bus_cycle_if;
    localparam int unsigned DW = 8;

    logic          actesc;
    logic          actlec;
    logic [DW-1:0] dirreg;
    logic [DW-1:0] datoreg;
    logic [DW-1:0] ad_in;
    logic [DW-1:0] ad_out;
    logic          ad_oe;
    logic          rtc_cs_n;
    logic          rtc_rd_n;
    logic          rtc_wr_n;
    logic          rtc_ad;
    logic          esclisto;
    logic          memorialisto;
    logic [DW-1:0] datomem;

    // Control FSM / pad side
    modport master (
        output actesc, actlec, dirreg, datoreg, ad_in,
        input  ad_out, ad_oe, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad,
               esclisto, memorialisto, datomem
    );

    // Bus-cycle generator side
    modport slave (
        input  actesc, actlec, dirreg, datoreg, ad_in,
        output ad_out, ad_oe, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad,
               esclisto, memorialisto, datomem
    );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Two-phase (address, then data) access generator for the external RTC's
// multiplexed AD bus. Optional feature macro: RTC_ADDR_CACHE_EN, which skips
// the address phase when the requested register was the last one addressed.
module rtc_bus_cycle #(
    parameter int unsigned T_PULSO = 10,
    parameter int unsigned T_GAP   = 5
) (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_cycle_if.slave bus
);
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] PULSO_LD = CNT_W'(T_PULSO - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(T_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_HOLD, GAP, DATA, DATA_HOLD, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;          // 1 = write, 0 = read
    logic [DW-1:0]    dir_q, dir_d;
    logic [DW-1:0]    dato_q, dato_d;
    logic [DW-1:0]    datomem_q, datomem_d;

    logic             cs_n_q, cs_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic             ad_q, ad_d;
    logic             oe_q, oe_d;
    logic [DW-1:0]    out_q, out_d;
    logic             esc_q, esc_d;
    logic             mem_q, mem_d;

`ifdef RTC_ADDR_CACHE_EN
    logic [DW-1:0]    cache_addr_q, cache_addr_d;
    logic             cache_vld_q, cache_vld_d;
`endif

    // State, counter, latched request and registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            dir_q     <= '0;
            dato_q    <= '0;
            datomem_q <= '0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_q      <= 1'b1;
            oe_q      <= 1'b0;
            out_q     <= '0;
            esc_q     <= 1'b0;
            mem_q     <= 1'b0;
`ifdef RTC_ADDR_CACHE_EN
            cache_addr_q <= '0;
            cache_vld_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dir_q     <= dir_d;
            dato_q    <= dato_d;
            datomem_q <= datomem_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_q      <= ad_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
            esc_q     <= esc_d;
            mem_q     <= mem_d;
`ifdef RTC_ADDR_CACHE_EN
            cache_addr_q <= cache_addr_d;
            cache_vld_q  <= cache_vld_d;
`endif
        end
    end

    // Next state, counter and latches; outputs decoded from the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dir_d     = dir_q;
        dato_d    = dato_q;
        datomem_d = datomem_q;
`ifdef RTC_ADDR_CACHE_EN
        cache_addr_d = cache_addr_q;
        cache_vld_d  = cache_vld_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.actesc || bus.actlec) begin
                    op_d    = bus.actesc;   // write wins when both are raised
                    dir_d   = bus.dirreg;
                    dato_d  = bus.datoreg;
                    cnt_d   = PULSO_LD;
                    state_d = ADDR;
`ifdef RTC_ADDR_CACHE_EN
                    if (cache_vld_q && (bus.dirreg == cache_addr_q)) begin
                        state_d = DATA;
                    end
`endif
                end
            end
            ADDR: begin
                if (cnt_q == '0) state_d = ADDR_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ADDR_HOLD: begin
                cnt_d   = GAP_LD;
                state_d = GAP;
`ifdef RTC_ADDR_CACHE_EN
                cache_addr_d = dir_q;
                cache_vld_d  = 1'b1;
`endif
            end
            GAP: begin
                if (cnt_q == '0) begin
                    cnt_d   = PULSO_LD;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    state_d = DATA_HOLD;
                    if (!op_q) datomem_d = bus.ad_in;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA_HOLD: state_d = DONE;
            DONE: begin
                if (!(op_q ? bus.actesc : bus.actlec)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = 1'b1;
        rd_n_d = 1'b1;
        wr_n_d = 1'b1;
        ad_d   = 1'b1;
        oe_d   = 1'b0;
        out_d  = '0;
        esc_d  = 1'b0;
        mem_d  = 1'b0;

        unique case (state_d)
            ADDR: begin
                cs_n_d = 1'b0;
                wr_n_d = 1'b0;
                ad_d   = 1'b0;
                oe_d   = 1'b1;
                out_d  = dir_d;
            end
            ADDR_HOLD: begin
                ad_d  = 1'b0;
                oe_d  = 1'b1;
                out_d = dir_d;
            end
            DATA: begin
                cs_n_d = 1'b0;
                if (op_d) begin
                    wr_n_d = 1'b0;
                    oe_d   = 1'b1;
                    out_d  = dato_d;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            DATA_HOLD: begin
                if (op_d) begin
                    oe_d  = 1'b1;
                    out_d = dato_d;
                end
            end
            DONE: begin
                esc_d = op_d;
                mem_d = !op_d;
            end
            default: ;
        endcase
    end

    assign bus.rtc_cs_n     = cs_n_q;
    assign bus.rtc_rd_n     = rd_n_q;
    assign bus.rtc_wr_n     = wr_n_q;
    assign bus.rtc_ad       = ad_q;
    assign bus.ad_oe        = oe_q;
    assign bus.ad_out       = out_q;
    assign bus.esclisto     = esc_q;
    assign bus.memorialisto = mem_q;
    assign bus.datomem      = datomem_q;
endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Directed bench for rtc_bus_cycle: edge-by-edge bus trace against a timing
// model, plus a scoreboard of completion flag / read byte per request.
module tb_rtc_bus_cycle;
    localparam int TP = 10;
    localparam int TG = 5;

    logic clk;
    logic reset;

    rtc_bus_cycle_if bus ();

    rtc_bus_cycle #(.T_PULSO(TP), .T_GAP(TG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [8:0] sb[$];          // {is_write, expected datomem}
    logic [7:0] dm_model  = 8'h00;
    logic       cache_vld = 1'b0;
    logic [7:0] cache_a   = 8'h00;

    localparam logic [22:0] RESET_VEC = {5'b11110, 8'h00, 2'b00, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [22:0] observed();
        return {bus.rtc_cs_n, bus.rtc_rd_n, bus.rtc_wr_n, bus.rtc_ad, bus.ad_oe,
                bus.ad_out, bus.esclisto, bus.memorialisto, bus.datomem};
    endfunction

    // Expected bus state after edge e of a cycle whose data phase starts at edge ds
    function automatic logic [22:0] exp_vec(input int e, input int ds, input int done_last,
                                            input logic wr, input logic [7:0] a,
                                            input logic [7:0] d, input logic [7:0] dm_old,
                                            input logic [7:0] dm_new);
        logic cs, rd, wn, ad, oe, esc, mem;
        logic [7:0] o, dm;
        cs = 1'b1; rd = 1'b1; wn = 1'b1; ad = 1'b1; oe = 1'b0;
        o = 8'h00; esc = 1'b0; mem = 1'b0; dm = dm_old;
        if (e < ds) begin
            if (e < TP) begin
                cs = 1'b0; wn = 1'b0; ad = 1'b0; oe = 1'b1; o = a;
            end else if (e == TP) begin
                ad = 1'b0; oe = 1'b1; o = a;
            end
        end else if (e < ds + TP) begin
            cs = 1'b0;
            if (wr) begin wn = 1'b0; oe = 1'b1; o = d; end
            else    rd = 1'b0;
        end else if (e == ds + TP) begin
            dm = dm_new;
            if (wr) begin oe = 1'b1; o = d; end
        end else begin
            dm = dm_new;
            if (e <= done_last) begin esc = wr; mem = !wr; end
        end
        return {cs, rd, wn, ad, oe, o, esc, mem, dm};
    endfunction

    // One request; hold = cycles the request stays up past the first flag cycle (0 = one-cycle pulse)
    task automatic run_cycle(input string name, input logic wr, input logic both,
                             input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] rv, input int hold);
        logic       hit;
        int         ds, done_e, drop_e, done_last;
        logic [7:0] dm_new;
        logic       seen;
        logic [8:0] item;
`ifdef RTC_ADDR_CACHE_EN
        hit = cache_vld && (a == cache_a);
`else
        hit = 1'b0;
`endif
        ds        = hit ? 0 : TP + TG + 1;
        done_e    = ds + TP + 1;
        drop_e    = (hold == 0) ? 0 : done_e + hold;
        done_last = (drop_e > done_e) ? drop_e : done_e;
        dm_new    = wr ? dm_model : rv;
        seen      = 1'b0;

        bus.actesc  = wr | both;
        bus.actlec  = !wr | both;
        bus.dirreg  = a;
        bus.datoreg = d;
        bus.ad_in   = ~rv;
        sb.push_back({wr, dm_new});

        for (int e = 0; e <= done_last + 1; e++) begin
            tick();
            check($sformatf("%s bus@%0d", name, e), observed(),
                  exp_vec(e, ds, done_last, wr, a, d, dm_model, dm_new));
            if ((bus.esclisto || bus.memorialisto) && !seen) begin
                seen = 1'b1;
                item = (sb.size() != 0) ? sb.pop_front() : 9'h1ff;
                check($sformatf("%s sb", name),
                      23'({bus.esclisto, bus.memorialisto, bus.datomem}),
                      23'({item[8], !item[8], item[7:0]}));
            end
            if (e == 2) begin
                bus.dirreg  = ~a;
                bus.datoreg = ~d;
            end
            if (!wr && e == ds + TP - 1) bus.ad_in = rv;
            if (e == drop_e) begin
                bus.actesc = 1'b0;
                bus.actlec = 1'b0;
            end
        end
        dm_model = dm_new;
        if (!hit) begin
            cache_vld = 1'b1;
            cache_a   = a;
        end
    endtask

    initial begin
        reset       = 1'b0;
        bus.actesc  = 1'b0;
        bus.actlec  = 1'b0;
        bus.dirreg  = 8'h00;
        bus.datoreg = 8'h00;
        bus.ad_in   = 8'h00;
        tick();
        check("reset_state", observed(), RESET_VEC);
        reset = 1'b1;
        tick();
        tick();
        check("idle_after_reset", observed(), RESET_VEC);

        run_cycle("wr21", 1'b1, 1'b0, 8'h21, 8'h59, 8'h00, 3);
        run_cycle("rd41", 1'b0, 1'b0, 8'h41, 8'hxx, 8'h12, 2);
        run_cycle("both30", 1'b1, 1'b1, 8'h30, 8'h77, 8'h00, 1);
        run_cycle("rd50_pulse", 1'b0, 1'b0, 8'h50, 8'h00, 8'hA5, 0);
        run_cycle("wr60_pulse", 1'b1, 1'b0, 8'h60, 8'h3C, 8'h00, 0);
        run_cycle("rd22_a", 1'b0, 1'b0, 8'h22, 8'h00, 8'h11, 0);
        run_cycle("rd22_b", 1'b0, 1'b0, 8'h22, 8'h00, 8'h66, 0);
        run_cycle("rd23", 1'b0, 1'b0, 8'h23, 8'h00, 8'h99, 0);

        // Reset in the middle of an address phase releases the bus at once
        bus.actesc  = 1'b1;
        bus.dirreg  = 8'h23;
        bus.datoreg = 8'hC3;
        for (int i = 0; i < 4; i++) tick();
        check("mid_addr_driving", 23'(bus.ad_oe), 23'(1'b1));
        reset = 1'b0;
        #1;
        check("async_reset", observed(), RESET_VEC);
        bus.actesc = 1'b0;
        tick();
        reset = 1'b1;
        dm_model  = 8'h00;
        cache_vld = 1'b0;
        tick();
        check("idle_after_abort", observed(), RESET_VEC);

        run_cycle("rd23_after_reset", 1'b0, 1'b0, 8'h23, 8'h00, 8'h5A, 0);

        check("sb_empty", 23'(sb.size()), 23'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
